// File: rtl/run_sequencer.sv
// Run controller: start/ack handshake, PC entry-point load, instruction-issue gating, cycle count and watchdog.
// All outputs come from flops or are decoded from flops; no input reaches an output within the same cycle.
`timescale 1ns/1ps
module run_sequencer #(
  parameter int MAX_CYCLES  = 4096,
  parameter int CNT_W       = 16,
  parameter int PC_W        = 32,
  parameter int PROG_STRIDE = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       prog_sel,
  input  logic             done,
  output logic             run_en,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_load_val,
  output logic             ack,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    ARM  = 3'd2,
    RUN  = 3'd3,
    FIN  = 3'd4,
    TOUT = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       prog_sel_q, prog_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_en_q, run_en_d;
  logic             pc_load_q, pc_load_d;
  logic             ack_q, ack_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    state_d    = state_q;
    prog_sel_d = prog_sel_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: if (start) state_d = HOLD;
      HOLD: begin
        if (!start) begin
          state_d    = ARM;
          prog_sel_d = prog_sel;
        end
      end
      ARM: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        // done has priority over the watchdog when both land on the last cycle
        if (done)                   state_d = FIN;
        else if (cnt_q == LAST_CNT) state_d = TOUT;
      end
      FIN:     if (start) state_d = HOLD;
      TOUT:    if (start) state_d = HOLD;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they align with the state they describe
    run_en_d  = (state_d == RUN);
    pc_load_d = (state_d == ARM);
    ack_d     = (state_d == FIN) || (state_d == TOUT);
    timeout_d = (state_d == TOUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      prog_sel_q <= '0;
      cnt_q      <= '0;
      run_en_q   <= 1'b0;
      pc_load_q  <= 1'b0;
      ack_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_sel_q <= prog_sel_d;
      cnt_q      <= cnt_d;
      run_en_q   <= run_en_d;
      pc_load_q  <= pc_load_d;
      ack_q      <= ack_d;
      timeout_q  <= timeout_d;
    end
  end

  // Entry point tracks the latched program index; pc_load alone qualifies it
  assign pc_load_val = PC_W'(prog_sel_q) * PC_W'(PROG_STRIDE);
  assign run_en      = run_en_q;
  assign pc_load     = pc_load_q;
  assign ack         = ack_q;
  assign timeout     = timeout_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench for run_sequencer, checked against a run-level model of the start/ack protocol.
`timescale 1ns/1ps
module tb_run_sequencer;
  localparam int MAX_CYCLES  = 4096;
  localparam int CNT_W       = 16;
  localparam int PC_W        = 32;
  localparam int PROG_STRIDE = 256;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       prog_sel = 2'd0;
  logic             done = 1'b0;
  logic             run_en, pc_load, ack, timeout;
  logic [PC_W-1:0]  pc_load_val;
  logic [CNT_W-1:0] cycle_count;

  int total = 0;
  int bad   = 0;

  run_sequencer #(
    .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W), .PC_W(PC_W), .PROG_STRIDE(PROG_STRIDE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .done(done),
    .run_en(run_en), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .ack(ack), .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".run_en"},  32'(run_en),  0);
    check({tag, ".pc_load"}, 32'(pc_load), 0);
    check({tag, ".ack"},     32'(ack),     0);
    check({tag, ".timeout"}, 32'(timeout), 0);
  endtask

  // One complete run. done_at: RUN cycle where done is raised (0 = never, so the watchdog fires).
  // abort_at: RUN cycle where reset is pulsed mid-cycle (0 = no abort).
  task automatic run_once(input int prog, input int hold, input int done_at, input int abort_at);
    int exp_cnt;
    logic [31:0] exp_pc;
    exp_pc = 32'(prog * PROG_STRIDE);
    start = 1'b1;
    prog_sel = 2'($urandom);
    tick();
    check("hold.ack_drop", 32'(ack), 0);
    for (int h = 1; h < hold; h++) begin
      done = 1'($urandom);
      prog_sel = 2'($urandom);
      tick();
      check_quiet("hold");
    end
    start = 1'b0;
    done = 1'($urandom);
    prog_sel = 2'(prog);
    tick();
    check("arm.pc_load", 32'(pc_load), 1);
    check("arm.pc_val", pc_load_val, exp_pc);
    check("arm.run_en", 32'(run_en), 0);
    check("arm.ack", 32'(ack), 0);
    prog_sel = 2'($urandom);
    done = 1'b0;
    tick();
    check("run1.pc_load", 32'(pc_load), 0);
    check("run1.pc_val", pc_load_val, exp_pc);
    for (int i = 1; i <= MAX_CYCLES; i++) begin
      if (i <= 12 || i % 1024 == 0 || i == done_at || i >= MAX_CYCLES - 1) begin
        check("run.run_en", 32'(run_en), 1);
        check("run.count", 32'(cycle_count), 32'(i - 1));
        check("run.ack", 32'(ack), 0);
      end
      if (i == abort_at) begin
        #2 reset = 1'b1;
        #1;
        check_quiet("abort");
        check("abort.count", 32'(cycle_count), 0);
        check("abort.pc_val", pc_load_val, 0);
        tick();
        reset = 1'b0;
        start = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 3; k++) begin
          done = 1'($urandom);
          tick();
          check_quiet("idle_after_abort");
        end
        done = 1'b0;
        return;
      end
      done  = (i == done_at);
      start = 1'($urandom);
      tick();
      if (i == done_at) break;
    end
    done  = 1'b0;
    start = 1'b0;
    exp_cnt = (done_at == 0) ? MAX_CYCLES : done_at;
    for (int k = 0; k < 3; k++) begin
      check("end.ack", 32'(ack), 1);
      check("end.timeout", 32'(timeout), (done_at == 0) ? 1 : 0);
      check("end.count", 32'(cycle_count), 32'(exp_cnt));
      check("end.run_en", 32'(run_en), 0);
      check("end.pc_load", 32'(pc_load), 0);
      done = 1'($urandom);
      tick();
    end
    done = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check_quiet("reset");
    check("reset.count", 32'(cycle_count), 0);
    check("reset.pc_val", pc_load_val, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_quiet("post_reset");

    // Program 2, start held 3 cycles
    run_once(2, 3, 7, 0);
    // Program 0, done on the 5th RUN cycle
    run_once(0, 1, 5, 0);
    // Watchdog expiry
    run_once(3, 2, 0, 0);
    // done coincides with the last allowed cycle
    run_once(1, 1, MAX_CYCLES, 0);
    // Rerun from TOUT-free FIN with program 1
    run_once(1, 2, 3, 0);
    // Reset in the 10th RUN cycle, then a fresh run from IDLE
    run_once(2, 1, 0, 10);
    run_once(3, 2, 4, 0);
    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      run_once(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
               int'($urandom_range(1, 40)), 0);
    end
    // A timeout followed directly by a short rerun
    run_once(0, 1, 0, 0);
    run_once(2, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
